// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control bundle bit positions,
// ID/EX stage state encoding and the EX-stage register payload.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 16;

  // Bit positions inside the packed EX/MEM/WB control bundle.
  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Everything the EX stage register carries for one instruction slot.
  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } ex_slot_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction sitting in decode. Purely combinational so a forwarding
// unit can reuse it later.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic              valid_e,
  input  logic              mem_read_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  output logic              load_use_c
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use_c = valid_e & mem_read_e & valid_d & (rt_e != '0) &
                 ((rt_e == rs_d) | (rt_e == rt_d));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// external hold and saturating bubble/hold event counters.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ImmD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              ValidD,
  input  logic              BranchTakenE,
  input  logic              ExtStall,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic              StallF,
  output logic              StallD,
  output logic [CNT_W-1:0]  BubbleCnt,
  output logic [CNT_W-1:0]  HoldCnt
);

  state_t            state_q, state_d;
  ex_slot_t          ex_q, ex_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              load_use;

  hazard_detect u_hazard (
    .valid_e    (ex_q.valid),
    .mem_read_e (ex_q.ctrl[CTRL_MEMREAD]),
    .rt_e       (ex_q.rt),
    .valid_d    (ValidD),
    .rs_d       (RsD),
    .rt_d       (RtD),
    .load_use_c (load_use)
  );

  // State, EX slot and counters: async clear to an empty slot in RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= RUN;
      ex_q         <= '0;
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next state and slot contents: hold > flush > load-use bubble > capture.
  always_comb begin
    state_d      = RUN;
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (ExtStall) begin
      state_d = HOLD;
      if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end else if (BranchTakenE) begin
      state_d = BUBBLE;
      ex_d    = '0;
    end else if (load_use) begin
      state_d = BUBBLE;
      ex_d    = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      ex_d = '{rd1: RD1D, rd2: RD2D, imm: ImmD, pc_plus4: PCPlus4D,
               rs: RsD, rt: RtD, rd: RdD, ctrl: CtrlD, valid: ValidD};
    end
  end

  // A taken branch flushes the dependent instruction, so it must not stall.
  always_comb begin
    StallF = ExtStall | (load_use & ~BranchTakenE);
    StallD = ExtStall | (load_use & ~BranchTakenE);
  end

  assign RD1E      = ex_q.rd1;
  assign RD2E      = ex_q.rd2;
  assign ImmE      = ex_q.imm;
  assign PCPlus4E  = ex_q.pc_plus4;
  assign RsE       = ex_q.rs;
  assign RtE       = ex_q.rt;
  assign RdE       = ex_q.rd;
  assign CtrlE     = ex_q.ctrl;
  assign ValidE    = ex_q.valid;
  assign BubbleCnt = bubble_cnt_q;
  assign HoldCnt   = hold_cnt_q;

  // An inserted bubble must always be an empty, control-free slot.
  a_bubble_empty: assert property (@(posedge CLK) disable iff (!RST_N)
    (state_q == BUBBLE) |-> (!ex_q.valid && (ex_q.ctrl == '0)));

  // Only the three defined encodings are reachable.
  a_state_legal: assert property (@(posedge CLK) disable iff (!RST_N)
    (state_q == RUN) || (state_q == BUBBLE) || (state_q == HOLD));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios plus random traffic,
// each cycle compared against a slot-level reference model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK;
  logic              RST_N;
  logic [DATA_W-1:0] RD1D, RD2D, ImmD, PCPlus4D;
  logic [REG_AW-1:0] RsD, RtD, RdD;
  logic [CTRL_W-1:0] CtrlD;
  logic              ValidD, BranchTakenE, ExtStall;
  logic [DATA_W-1:0] RD1E, RD2E, ImmE, PCPlus4E;
  logic [REG_AW-1:0] RsE, RtE, RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              ValidE, StallF, StallD;
  logic [CNT_W-1:0]  BubbleCnt, HoldCnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the EX slot and counters
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [REG_AW-1:0] m_rs, m_rt, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  bit                m_valid;
  int                m_bub, m_hold;

  id_ex_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .PCPlus4D(PCPlus4D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .CtrlD(CtrlD), .ValidD(ValidD),
    .BranchTakenE(BranchTakenE), .ExtStall(ExtStall),
    .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCPlus4E(PCPlus4E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD),
    .BubbleCnt(BubbleCnt), .HoldCnt(HoldCnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0; m_valid = 0;
    m_bub = 0; m_hold = 0;
  endtask

  // A load in EX writing a nonzero register that decode reads
  function automatic bit model_lu();
    logic [CTRL_W-1:0] c;
    c = m_ctrl;
    return m_valid && c[1] && ValidD && (m_rt != 0) && (m_rt == RsD || m_rt == RtD);
  endfunction

  task automatic model_edge();
    bit lu;
    lu = model_lu();
    if (ExtStall) begin
      if (m_hold < CNT_MAX) m_hold++;
    end else if (BranchTakenE || lu) begin
      m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0; m_valid = 0;
      if (!BranchTakenE && m_bub < CNT_MAX) m_bub++;
    end else begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmD; m_pc = PCPlus4D;
      m_rs = RsD; m_rt = RtD; m_rd = RdD; m_ctrl = CtrlD; m_valid = ValidD;
    end
  endtask

  task automatic check_outputs();
    check("RD1E", 64'(RD1E), 64'(m_rd1));
    check("RD2E", 64'(RD2E), 64'(m_rd2));
    check("ImmE", 64'(ImmE), 64'(m_imm));
    check("PCPlus4E", 64'(PCPlus4E), 64'(m_pc));
    check("RsE", 64'(RsE), 64'(m_rs));
    check("RtE", 64'(RtE), 64'(m_rt));
    check("RdE", 64'(RdE), 64'(m_rd));
    check("CtrlE", 64'(CtrlE), 64'(m_ctrl));
    check("ValidE", 64'(ValidE), 64'(m_valid));
    check("BubbleCnt", 64'(BubbleCnt), 64'(m_bub));
    check("HoldCnt", 64'(HoldCnt), 64'(m_hold));
  endtask

  // Inputs are set by the caller right after a falling edge.
  task automatic step(input bit chk);
    bit exp_stall;
    #1;
    if (chk) begin
      exp_stall = ExtStall || (model_lu() && !BranchTakenE);
      check("StallF", 64'(StallF), 64'(exp_stall));
      check("StallD", 64'(StallD), 64'(exp_stall));
    end
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (chk) check_outputs();
  endtask

  task automatic set_d(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] rd, input logic [CTRL_W-1:0] ctrl);
    RsD = rs; RtD = rt; RdD = rd; CtrlD = ctrl; ValidD = 1'b1;
    RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; PCPlus4D = $urandom;
    BranchTakenE = 1'b0; ExtStall = 1'b0;
  endtask

  task automatic rand_inputs();
    RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; PCPlus4D = $urandom;
    RsD = REG_AW'($urandom_range(0, 3));
    RtD = REG_AW'($urandom_range(0, 3));
    RdD = REG_AW'($urandom_range(0, 31));
    CtrlD = CTRL_W'($urandom);
    ValidD = ($urandom_range(0, 9) != 0);
    BranchTakenE = ($urandom_range(0, 9) == 0);
    ExtStall = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    RST_N = 1'b0;
    RD1D = '0; RD2D = '0; ImmD = '0; PCPlus4D = '0;
    RsD = '0; RtD = '0; RdD = '0; CtrlD = '0;
    ValidD = 1'b0; BranchTakenE = 1'b0; ExtStall = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_outputs();
    check("StallF_rst", 64'(StallF), 64'd0);
    RST_N = 1'b1;

    // ADD r3,r1,r2 with operands 5 and 7
    set_d(5'd1, 5'd2, 5'd3, 8'h01);
    RD1D = 32'd5; RD2D = 32'd7;
    step(1);
    check("add_RD1E", 64'(RD1E), 64'd5);
    check("add_RD2E", 64'(RD2E), 64'd7);
    check("add_ValidE", 64'(ValidE), 64'd1);

    // LW r4 enters EX, then a consumer of r4 in decode
    set_d(5'd1, 5'd4, 5'd0, 8'h03);
    step(1);
    set_d(5'd4, 5'd5, 5'd6, 8'h01);
    #1;
    check("lu_StallF", 64'(StallF), 64'd1);
    step(1);
    check("lu_bubble_ctrl", 64'(CtrlE), 64'd0);
    check("lu_bubble_valid", 64'(ValidE), 64'd0);
    check("lu_BubbleCnt", 64'(BubbleCnt), 64'd1);
    step(1);
    check("lu_captured_rs", 64'(RsE), 64'd4);
    check("lu_captured_valid", 64'(ValidE), 64'd1);

    // Load to r0 followed by r0 readers: no hazard
    set_d(5'd0, 5'd0, 5'd0, 8'h03);
    step(1);
    set_d(5'd0, 5'd0, 5'd7, 8'h01);
    #1;
    check("r0_StallF", 64'(StallF), 64'd0);
    step(1);
    check("r0_ValidE", 64'(ValidE), 64'd1);
    check("r0_BubbleCnt", 64'(BubbleCnt), 64'd1);

    // External hold for 3 cycles with a branch pulse in the middle
    set_d(5'd2, 5'd3, 5'd8, 8'h01);
    RD1D = 32'h1234;
    step(1);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      ExtStall = 1'b1;
      BranchTakenE = (i == 1);
      step(1);
    end
    check("hold_RD1E", 64'(RD1E), 64'h1234);
    check("hold_HoldCnt", 64'(HoldCnt), 64'd3);

    // Branch flush coincident with a load-use hazard
    set_d(5'd1, 5'd9, 5'd0, 8'h03);
    step(1);
    set_d(5'd9, 5'd1, 5'd2, 8'h01);
    BranchTakenE = 1'b1;
    #1;
    check("br_lu_StallD", 64'(StallD), 64'd0);
    step(1);
    check("br_lu_ValidE", 64'(ValidE), 64'd0);
    check("br_lu_BubbleCnt", 64'(BubbleCnt), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step(1);
    end

    // Asynchronous reset in the middle of a cycle
    rand_inputs();
    ExtStall = 1'b0; BranchTakenE = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      step(1);
    end

    // Long hold to drive HoldCnt into saturation
    rand_inputs();
    ExtStall = 1'b1;
    for (int i = 0; i < CNT_MAX + 4; i++) step(0);
    check_outputs();
    check("sat_HoldCnt", 64'(HoldCnt), 64'hFFFF);
    step(1);
    check("sat_HoldCnt_stays", 64'(HoldCnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
